dma_channel_counter: RTL and testbench

Downstream consumer of the DMA byte-assembly write buffer. Captures each assembled 16-bit word into the channel's base address or base word-count register, then runs the channel's current address/count during transfers. Each acknowledged transfer steps the address and decrements the count. Flags terminal count (TC) and optionally auto-reinitialises from the base registers.

---
 rtl/dma_channel_counter.sv | 130 +++++++++++++
 tb/tb_dma_channel_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dma_channel_counter.sv
// DMA channel address/count engine: captures programmed base words, steps the live
// address/count on each acknowledged transfer, and flags terminal count.
module dma_channel_counter (
   input  logic        clk,
   input  logic        RESET,
   input  logic [15:0] prog_word,
   input  logic        prog_valid,
   input  logic        prog_sel,
   input  logic        autoinit_en,
   input  logic        addr_dec,
   input  logic        xfer_ack,
   output logic [15:0] cur_addr,
   output logic [15:0] cur_count,
   output logic        ready,
   output logic        done,
   output logic        tc,
   output logic        err
);

   localparam int unsigned W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           prog_valid_q;
   logic [W-1:0]   base_addr_q, base_addr_d;
   logic [W-1:0]   base_count_q, base_count_d;
   logic [W-1:0]   cur_addr_q, cur_addr_d;
   logic [W-1:0]   cur_count_q, cur_count_d;
   logic           addr_loaded_q, addr_loaded_d;
   logic           cnt_loaded_q, cnt_loaded_d;
   logic           tc_q, tc_d;
   logic           err_q, err_d;
   logic           load_c;
   logic [W-1:0]   addr_step_c;

   // A held-high prog_valid produces exactly one load on its rising edge.
   assign load_c      = prog_valid & ~prog_valid_q;
   assign addr_step_c = addr_dec ? (cur_addr_q - W'(1)) : (cur_addr_q + W'(1));

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         prog_valid_q  <= 1'b0;
         base_addr_q   <= '0;
         base_count_q  <= '0;
         cur_addr_q    <= '0;
         cur_count_q   <= '0;
         addr_loaded_q <= 1'b0;
         cnt_loaded_q  <= 1'b0;
         tc_q          <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         prog_valid_q  <= prog_valid;
         base_addr_q   <= base_addr_d;
         base_count_q  <= base_count_d;
         cur_addr_q    <= cur_addr_d;
         cur_count_q   <= cur_count_d;
         addr_loaded_q <= addr_loaded_d;
         cnt_loaded_q  <= cnt_loaded_d;
         tc_q          <= tc_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      base_addr_d   = base_addr_q;
      base_count_d  = base_count_q;
      cur_addr_d    = cur_addr_q;
      cur_count_d   = cur_count_q;
      addr_loaded_d = addr_loaded_q;
      cnt_loaded_d  = cnt_loaded_q;
      tc_d          = 1'b0;
      err_d         = 1'b0;

      if (load_c) begin
         // A coincident ack loses to the load and is reported as dropped.
         err_d = xfer_ack;
         if (!prog_sel) begin
            base_addr_d   = prog_word;
            cur_addr_d    = prog_word;
            addr_loaded_d = 1'b1;
         end else begin
            base_count_d = prog_word;
            cur_count_d  = prog_word;
            cnt_loaded_d = 1'b1;
         end
         case (state_q)
            ST_IDLE:  if (addr_loaded_d && cnt_loaded_d) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end else if (xfer_ack) begin
         if (state_q == ST_READY) begin
            cur_addr_d = addr_step_c;
            if (cur_count_q != '0) begin
               cur_count_d = cur_count_q - W'(1);
            end else begin
               tc_d = 1'b1;
               if (autoinit_en) begin
                  cur_addr_d  = base_addr_q;
                  cur_count_d = base_count_q;
               end else begin
                  cur_count_d   = '1;
                  addr_loaded_d = 1'b0;
                  cnt_loaded_d  = 1'b0;
                  state_d       = ST_DONE;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign cur_addr  = cur_addr_q;
   assign cur_count = cur_count_q;
   assign ready     = (state_q == ST_READY);
   assign done      = (state_q == ST_DONE);
   assign tc        = tc_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dma_channel_counter.sv
// Self-checking bench for dma_channel_counter: directed scenarios then randomized
// traffic, all compared against a behavioural channel model.
module tb_dma_channel_counter;

   logic        clk = 1'b0;
   logic        RESET;
   logic [15:0] prog_word;
   logic        prog_valid, prog_sel, autoinit_en, addr_dec, xfer_ack;
   logic [15:0] cur_addr, cur_count;
   logic        ready, done, tc, err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Behavioural channel model
   logic [15:0] m_addr, m_count, m_baddr, m_bcount;
   logic        m_al, m_cl, m_ready, m_done, m_pvq, e_tc, e_err;

   always #5 clk = ~clk;

   dma_channel_counter dut (
      .clk(clk), .RESET(RESET), .prog_word(prog_word), .prog_valid(prog_valid),
      .prog_sel(prog_sel), .autoinit_en(autoinit_en), .addr_dec(addr_dec),
      .xfer_ack(xfer_ack), .cur_addr(cur_addr), .cur_count(cur_count),
      .ready(ready), .done(done), .tc(tc), .err(err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_addr = '0; m_count = '0; m_baddr = '0; m_bcount = '0;
      m_al = 0; m_cl = 0; m_ready = 0; m_done = 0; m_pvq = 0; e_tc = 0; e_err = 0;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".addr"},  32'(cur_addr),  32'(m_addr));
      check_eq({tag, ".count"}, 32'(cur_count), 32'(m_count));
      check_eq({tag, ".ready"}, 32'(ready),     32'(m_ready));
      check_eq({tag, ".done"},  32'(done),      32'(m_done));
      check_eq({tag, ".tc"},    32'(tc),        32'(e_tc));
      check_eq({tag, ".err"},   32'(err),       32'(e_err));
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then check.
   task automatic step(input string tag, input logic pv, input logic sel, input logic [15:0] w,
                       input logic ae, input logic ad, input logic ack);
      logic ld;
      prog_valid = pv; prog_sel = sel; prog_word = w;
      autoinit_en = ae; addr_dec = ad; xfer_ack = ack;
      @(posedge clk);
      ld = pv && !m_pvq;
      m_pvq = pv;
      e_tc = 0; e_err = 0;
      if (ld) begin
         e_err = ack;
         if (!sel) begin m_addr = w; m_baddr = w; m_al = 1; end
         else      begin m_count = w; m_bcount = w; m_cl = 1; end
         m_done  = 0;
         m_ready = m_al && m_cl;
      end else if (ack) begin
         if (!m_ready) e_err = 1;
         else begin
            m_addr = ad ? 16'(m_addr - 16'd1) : 16'(m_addr + 16'd1);
            if (m_count != 0) m_count = 16'(m_count - 16'd1);
            else begin
               e_tc = 1;
               if (ae) begin m_addr = m_baddr; m_count = m_bcount; end
               else begin
                  m_count = 16'hFFFF; m_ready = 0; m_done = 1; m_al = 0; m_cl = 0;
               end
            end
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic load(input string tag, input logic sel, input logic [15:0] w);
      step(tag, 1'b1, sel, w, 1'b0, 1'b0, 1'b0);
      step(tag, 1'b0, sel, w, 1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      #2 RESET = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1 RESET = 1'b0;
   endtask

   initial begin
      logic pv_r;
      RESET = 1'b1; prog_word = '0; prog_valid = 0; prog_sel = 0;
      autoinit_en = 0; addr_dec = 0; xfer_ack = 0;
      model_reset();
      #12;
      check_all("reset");
      RESET = 1'b0;
      @(posedge clk); #1;

      // Program and run to TC without auto-init
      step("ld_addr", 1, 0, 16'h1234, 0, 0, 0);
      step("ld_gap", 0, 0, 16'h0, 0, 0, 0);
      step("ld_cnt", 1, 1, 16'h0002, 0, 0, 0);
      check_eq("armed.addr", 32'(cur_addr), 32'h1234);
      check_eq("armed.ready", 32'(ready), 32'h1);
      step("ack1", 0, 0, 0, 0, 0, 1);
      step("ack2", 0, 0, 0, 0, 0, 1);
      step("ack3", 0, 0, 0, 0, 0, 1);
      check_eq("tc3.count", 32'(cur_count), 32'hFFFF);
      check_eq("tc3.tc", 32'(tc), 32'h1);
      step("ack4_done", 0, 0, 0, 0, 0, 1);
      check_eq("done.err", 32'(err), 32'h1);

      // Auto-init with decrementing address
      load("ai_addr", 0, 16'h1234);
      load("ai_cnt", 1, 16'h0002);
      for (int i = 0; i < 3; i++) step("ai_ack", 0, 0, 0, 1, 1, 1);
      check_eq("ai.reload_addr", 32'(cur_addr), 32'h1234);
      check_eq("ai.ready", 32'(ready), 32'h1);

      // Address wrap both directions (live re-target while READY)
      load("wrap_addr", 0, 16'hFFFF);
      load("wrap_cnt", 1, 16'h0005);
      step("wrap_up", 0, 0, 0, 0, 0, 1);
      check_eq("wrap_up.addr", 32'(cur_addr), 32'h0000);
      load("wrap_addr0", 0, 16'h0000);
      step("wrap_dn", 0, 0, 0, 0, 1, 1);
      check_eq("wrap_dn.addr", 32'(cur_addr), 32'hFFFF);

      // Held prog_valid gives one load; load+ack collision
      for (int i = 0; i < 5; i++) step("held", 1, 0, 16'h4000 + 16'(i), 0, 0, 0);
      step("held_end", 0, 0, 0, 0, 0, 0);
      step("collide", 1, 0, 16'hABCD, 0, 0, 1);
      check_eq("collide.err", 32'(err), 32'h1);
      step("collide_end", 0, 0, 0, 0, 0, 0);

      // Reset mid-sequence, then ack in IDLE
      load("rs_cnt", 1, 16'h0003);
      async_reset("mid_reset");
      step("post_rst_ack", 0, 0, 0, 0, 0, 1);
      check_eq("post_rst.err", 32'(err), 32'h1);

      // Randomized traffic
      pv_r = 0;
      for (int i = 0; i < 600; i++) begin
         logic sel;
         logic [15:0] w;
         if ($urandom_range(0, 99) < 25) pv_r = ~pv_r;
         sel = 1'($urandom_range(0, 1));
         w = sel ? 16'($urandom_range(0, 4)) : 16'($urandom);
         step("rand", pv_r, sel, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 60));
         if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
